ov7670_capture: RTL and testbench

Camera-side capture stage feeding the frame-buffer write controller. Samples the OV7670 parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain and emits one-cycle pixel-byte strobes (`pix_valid`/`cam_data`) plus a `frame_done` pulse. Groups bytes into Ethernet-sized chunks and drops a whole chunk when the downstream writer is not ready at its start, because the camera cannot be stalled. Also reports line/frame integrity.

---
 rtl/ov7670_capture.sv | 195 +++++++++++++++++++
 tb/tb_ov7670_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: synchronizes the camera bus into clk, forwards bytes
// in writer-sized chunks (dropping whole chunks when the writer is busy) and checks frame geometry.
module ov7670_capture #(
    parameter int LINE_BYTES  = 1280,
    parameter int FRAME_LINES = 480,
    parameter int CHUNK_BYTES = 1280
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_d,
    input  logic        enable,
    input  logic        sink_ready,
    output logic        pix_valid,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        chunk_start,
    output logic [9:0]  line_cnt,
    output logic [15:0] drop_cnt,
    output logic        frame_err,
    output logic [1:0]  FSM_state
);

    localparam int CW = (CHUNK_BYTES > 1) ? $clog2(CHUNK_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2,
        UNUSED     = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'd1023) ? v : v + 10'd1;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [1:0]      pclk_sync_r;
    logic [1:0]      vsync_sync_r;
    logic [1:0]      href_sync_r;
    logic [1:0][7:0] d_pipe_r;
    logic            pclk_prev_r;
    logic            vsync_prev_r;
    logic            href_prev_r;
    logic [15:0]     line_bytes_r;
    logic [CW-1:0]   chunk_cnt_r;
    logic            chunk_acc_r;
    logic            pix_valid_r;
    logic [7:0]      cam_data_r;
    logic            frame_done_r;
    logic            chunk_start_r;
    logic [9:0]      line_cnt_r;
    logic [15:0]     drop_cnt_r;
    logic            frame_err_r;

    logic            byte_evt_s;
    logic            line_end_s;
    logic            vsync_rise_s;
    logic            vsync_fall_s;
    logic            in_active_s;
    logic            frame_end_s;
    logic            byte_act_s;
    logic            line_end_act_s;
    logic            start_frame_s;
    logic            chunk_first_s;
    logic            fwd_s;
    logic            line_len_bad_s;
    logic [9:0]      line_cnt_next_s;

    // Two-flop synchronizers, matching data delay line and edge-detect history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk_sync_r  <= 2'b00;
            vsync_sync_r <= 2'b00;
            href_sync_r  <= 2'b00;
            d_pipe_r     <= '0;
            pclk_prev_r  <= 1'b0;
            vsync_prev_r <= 1'b0;
            href_prev_r  <= 1'b0;
        end else begin
            pclk_sync_r  <= {pclk_sync_r[0], cam_pclk};
            vsync_sync_r <= {vsync_sync_r[0], cam_vsync};
            href_sync_r  <= {href_sync_r[0], cam_href};
            d_pipe_r     <= {d_pipe_r[0], cam_d};
            pclk_prev_r  <= pclk_sync_r[1];
            vsync_prev_r <= vsync_sync_r[1];
            href_prev_r  <= href_sync_r[1];
        end
    end

    // Event decode; a frame end in ACTIVE swallows a coincident byte
    always_comb begin
        byte_evt_s      = pclk_sync_r[1] & ~pclk_prev_r & href_sync_r[1];
        line_end_s      = href_prev_r & ~href_sync_r[1];
        vsync_rise_s    = vsync_sync_r[1] & ~vsync_prev_r;
        vsync_fall_s    = vsync_prev_r & ~vsync_sync_r[1];
        in_active_s     = (state_r == ACTIVE);
        frame_end_s     = in_active_s & vsync_rise_s;
        byte_act_s      = in_active_s & byte_evt_s & ~vsync_rise_s;
        line_end_act_s  = in_active_s & line_end_s;
        start_frame_s   = (state_r == WAIT_FRAME) & vsync_fall_s;
        chunk_first_s   = byte_act_s & (chunk_cnt_r == '0);
        fwd_s           = byte_act_s & (chunk_first_s ? sink_ready : chunk_acc_r);
        line_len_bad_s  = line_end_act_s & (line_bytes_r != 16'(LINE_BYTES));
        line_cnt_next_s = line_end_act_s ? sat_inc10(line_cnt_r) : line_cnt_r;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; enable only matters at frame boundaries
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (vsync_rise_s && enable) next_state_s = WAIT_FRAME;
                else                        next_state_s = IDLE;
            end
            WAIT_FRAME: begin
                if (vsync_fall_s) next_state_s = ACTIVE;
                else              next_state_s = WAIT_FRAME;
            end
            ACTIVE: begin
                if (vsync_rise_s) next_state_s = enable ? WAIT_FRAME : IDLE;
                else              next_state_s = ACTIVE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Chunking, byte/line counters, integrity flag and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_bytes_r  <= 16'd0;
            chunk_cnt_r   <= '0;
            chunk_acc_r   <= 1'b0;
            pix_valid_r   <= 1'b0;
            cam_data_r    <= 8'd0;
            frame_done_r  <= 1'b0;
            chunk_start_r <= 1'b0;
            line_cnt_r    <= 10'd0;
            drop_cnt_r    <= 16'd0;
            frame_err_r   <= 1'b0;
        end else begin
            pix_valid_r   <= fwd_s;
            chunk_start_r <= chunk_first_s & sink_ready;
            frame_done_r  <= frame_end_s;
            if (fwd_s) cam_data_r <= d_pipe_r[1];
            if (start_frame_s) begin
                line_bytes_r <= 16'd0;
                chunk_cnt_r  <= '0;
                chunk_acc_r  <= 1'b0;
                line_cnt_r   <= 10'd0;
                frame_err_r  <= 1'b0;
            end else if (in_active_s) begin
                line_cnt_r <= line_cnt_next_s;
                // The frame-length check sees the line count including a coincident line end
                if (line_len_bad_s || (frame_end_s && (line_cnt_next_s != 10'(FRAME_LINES))))
                    frame_err_r <= 1'b1;
                if (line_end_act_s)  line_bytes_r <= 16'd0;
                else if (byte_act_s) line_bytes_r <= sat_inc16(line_bytes_r);
                if (byte_act_s) begin
                    chunk_cnt_r <= (chunk_cnt_r == CW'(CHUNK_BYTES - 1)) ? '0 : chunk_cnt_r + CW'(1);
                    if (chunk_first_s) begin
                        chunk_acc_r <= sink_ready;
                        if (!sink_ready) drop_cnt_r <= sat_inc16(drop_cnt_r);
                    end
                end
            end
        end
    end

    assign pix_valid   = pix_valid_r;
    assign cam_data    = cam_data_r;
    assign frame_done  = frame_done_r;
    assign chunk_start = chunk_start_r;
    assign line_cnt    = line_cnt_r;
    assign drop_cnt    = drop_cnt_r;
    assign frame_err   = frame_err_r;
    assign FSM_state   = state_r;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with an 8-byte line, 4-line frame and 8-byte chunk geometry.
module tb_ov7670_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_d;
    logic        enable, sink_ready;
    logic        pix_valid;
    logic [7:0]  cam_data;
    logic        frame_done, chunk_start;
    logic [9:0]  line_cnt;
    logic [15:0] drop_cnt;
    logic        frame_err;
    logic [1:0]  FSM_state;

    int n_chk  = 0;
    int n_fail = 0;

    int         pix_cnt = 0;
    int         cs_cnt = 0;
    int         fd_cnt = 0;
    int         shape_err = 0;
    logic       pv_d1 = 1'b0;
    logic       pv_d2 = 1'b0;
    logic [7:0] got_q[$];

    ov7670_capture #(.LINE_BYTES(8), .FRAME_LINES(4), .CHUNK_BYTES(8)) dut (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_d(cam_d), .enable(enable), .sink_ready(sink_ready),
        .pix_valid(pix_valid), .cam_data(cam_data), .frame_done(frame_done),
        .chunk_start(chunk_start), .line_cnt(line_cnt), .drop_cnt(drop_cnt),
        .frame_err(frame_err), .FSM_state(FSM_state)
    );

    always #5 clk = ~clk;

    // Output monitor: collects forwarded bytes and pulse counts, flags malformed strobes
    always @(negedge clk) begin
        if (pix_valid) begin
            pix_cnt <= pix_cnt + 1;
            got_q.push_back(cam_data);
            if (pv_d1 || pv_d2) shape_err <= shape_err + 1;
        end
        if (chunk_start) cs_cnt <= cs_cnt + 1;
        if (chunk_start && !pix_valid) shape_err <= shape_err + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        pv_d1 <= pix_valid;
        pv_d2 <= pv_d1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit chk_lat, input bit exp_fwd, input bit exp_cs);
        @(negedge clk);
        cam_pclk = 1'b0; cam_d = d; cam_href = 1'b1;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
        if (chk_lat) chk("latency_early", 32'(pix_valid), 32'd0);
        @(negedge clk);
        if (chk_lat) begin
            chk("latency_pix_valid", 32'(pix_valid), 32'(exp_fwd));
            chk("chunk_start", 32'(chunk_start), 32'(exp_cs));
            if (exp_fwd) chk("cam_data", 32'(cam_data), 32'(d));
        end
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] base, input bit exp_fwd, input bit exp_cs);
        for (int i = 0; i < nbytes; i++)
            send_byte(8'(base + 8'(i)), (i == 0), exp_fwd, exp_cs);
        @(negedge clk);
        cam_pclk = 1'b0; cam_href = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int nlines, input int short_line, input logic [3:0] drop_mask,
                              input int dis_line, input bit active, input logic [7:0] base);
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clk);
        if (active) begin
            chk("frame_start_err", 32'(frame_err), 32'd0);
            chk("frame_start_line_cnt", 32'(line_cnt), 32'd0);
            chk("frame_start_state", 32'(FSM_state), 32'd2);
        end
        for (int l = 0; l < nlines; l++) begin
            if (l == dis_line) enable = 1'b0;
            sink_ready = ~drop_mask[l];
            send_line((l == short_line) ? 7 : 8, 8'(base + 8'(8 * l)), active & ~drop_mask[l],
                      active & ~drop_mask[l] & ((short_line < 0) || (l <= short_line)));
            if (l == short_line) chk("short_line_err", 32'(frame_err), 32'd1);
        end
        sink_ready = 1'b1;
        if (active) chk("pre_end_err", 32'(frame_err), 32'(short_line >= 0));
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int p0, c0, f0, q0;
        reset = 1'b1; enable = 1'b1; sink_ready = 1'b1;
        cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_cam_data", 32'(cam_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_chunk_start", 32'(chunk_start), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_state", 32'(FSM_state), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal frame
        p0 = pix_cnt; c0 = cs_cnt; f0 = fd_cnt; q0 = got_q.size();
        send_frame(4, -1, 4'b0000, -1, 1'b1, 8'h10);
        chk("nom_pix", 32'(pix_cnt - p0), 32'd32);
        chk("nom_chunks", 32'(cs_cnt - c0), 32'd4);
        chk("nom_frame_done", 32'(fd_cnt - f0), 32'd1);
        chk("nom_frame_err", 32'(frame_err), 32'd0);
        chk("nom_line_cnt", 32'(line_cnt), 32'd4);
        chk("nom_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("nom_state", 32'(FSM_state), 32'd1);
        for (int i = 0; i < 32; i++)
            if (q0 + i < got_q.size()) chk("nom_byte", 32'(got_q[q0 + i]), 32'(8'h10 + 8'(i)));

        // Second chunk dropped
        p0 = pix_cnt; c0 = cs_cnt; q0 = got_q.size();
        send_frame(4, -1, 4'b0010, -1, 1'b1, 8'h40);
        chk("drop_pix", 32'(pix_cnt - p0), 32'd24);
        chk("drop_chunks", 32'(cs_cnt - c0), 32'd3);
        chk("drop_cnt", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 24; i++)
            if (q0 + i < got_q.size())
                chk("drop_byte", 32'(got_q[q0 + i]), 32'(8'h40 + 8'((i < 8) ? i : i + 8)));

        // Short line, then clean frame, then short frame
        p0 = pix_cnt; c0 = cs_cnt; f0 = fd_cnt;
        send_frame(4, 2, 4'b0000, -1, 1'b1, 8'h80);
        chk("short_pix", 32'(pix_cnt - p0), 32'd31);
        chk("short_chunks", 32'(cs_cnt - c0), 32'd4);
        chk("short_frame_done", 32'(fd_cnt - f0), 32'd1);
        chk("short_err_held", 32'(frame_err), 32'd1);
        send_frame(4, -1, 4'b0000, -1, 1'b1, 8'h20);
        chk("clean_err", 32'(frame_err), 32'd0);
        send_frame(3, -1, 4'b0000, -1, 1'b1, 8'h30);
        chk("three_line_err", 32'(frame_err), 32'd1);
        chk("three_line_cnt", 32'(line_cnt), 32'd3);

        // Async reset in the middle of a line
        @(negedge clk);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_state", 32'(FSM_state), 32'd2);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + 8'(i)), 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("mid_rst_cam_data", 32'(cam_data), 32'd0);
        chk("mid_rst_line_cnt", 32'(line_cnt), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
        chk("mid_rst_state", 32'(FSM_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        p0 = pix_cnt;
        for (int i = 5; i < 8; i++) send_byte(8'(8'hC0 + 8'(i)), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cam_pclk = 1'b0; cam_href = 1'b0;
        repeat (4) @(negedge clk);
        send_line(8, 8'hC8, 1'b0, 1'b0);
        chk("post_rst_no_pix", 32'(pix_cnt - p0), 32'd0);
        chk("post_rst_state", 32'(FSM_state), 32'd0);
        send_frame(4, -1, 4'b0000, -1, 1'b1, 8'h60);
        chk("post_rst_frame_pix", 32'(pix_cnt - p0), 32'd32);

        // Enable dropped mid-frame
        p0 = pix_cnt; f0 = fd_cnt;
        send_frame(4, -1, 4'b0000, 2, 1'b1, 8'hE0);
        chk("dis_pix", 32'(pix_cnt - p0), 32'd32);
        chk("dis_frame_done", 32'(fd_cnt - f0), 32'd1);
        chk("dis_state", 32'(FSM_state), 32'd0);
        p0 = pix_cnt; f0 = fd_cnt;
        send_frame(4, -1, 4'b0000, -1, 1'b0, 8'hA0);
        chk("disabled_no_pix", 32'(pix_cnt - p0), 32'd0);
        chk("disabled_no_frame_done", 32'(fd_cnt - f0), 32'd0);
        chk("disabled_state", 32'(FSM_state), 32'd0);

        // Drop counter saturation from a preloaded value
        enable = 1'b1;
        @(negedge clk);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clk);
        force dut.drop_cnt_r = 16'hFFFD;
        @(negedge clk);
        release dut.drop_cnt_r;
        @(negedge clk);
        chk("preload_drop_cnt", 32'(drop_cnt), 32'h0000FFFD);
        send_frame(4, -1, 4'b0001, -1, 1'b1, 8'h00);
        chk("drop_cnt_fffe", 32'(drop_cnt), 32'h0000FFFE);
        p0 = pix_cnt;
        send_frame(4, -1, 4'b1111, -1, 1'b1, 8'h00);
        chk("drop_cnt_sat", 32'(drop_cnt), 32'h0000FFFF);
        chk("all_dropped_pix", 32'(pix_cnt - p0), 32'd0);

        chk("pulse_shape", 32'(shape_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
